// File: rtl/uart_tx_cfg.sv
// rtl/uart_tx_cfg.sv - runtime-configurable UART transmitter
// 5-9 data bits, none/even/odd parity, 1/1.5/2 stop bits, break and mark-after-break.
module uart_tx_cfg #(
  parameter int   OS       = 16,
  parameter logic IDLE_LVL = 1'b1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       b_tick,
  input  logic       tx_valid,
  input  logic [8:0] tx_data,
  output logic       tx_ready,
  input  logic [3:0] cfg_db,
  input  logic [1:0] cfg_par,
  input  logic [1:0] cfg_stop,
  input  logic       brk,
  output logic       tx,
  output logic       tx_done_tick,
  output logic       busy
);

  localparam int TW = $clog2(OS);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;
  localparam logic [2:0] S_BREAK  = 3'd5;
  localparam logic [2:0] S_MAB    = 3'd6;

  logic [2:0]    state_q, state_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [3:0]    bit_q, bit_d;
  logic [8:0]    shreg_q, shreg_d;
  logic [3:0]    db_q, db_d;
  logic          par_en_q, par_en_d;
  logic          par_bit_q, par_bit_d;
  logic [1:0]    stop_q, stop_d;
  logic          tx_q, tx_d;
  logic          done_q, done_d;

  logic [3:0] db_clamped;
  logic [8:0] data_mask;
  logic       tick_end;
  logic       stop_last;
  logic       counting;

  always_comb begin
    if (cfg_db < 4'd5)      db_clamped = 4'd5;
    else if (cfg_db > 4'd9) db_clamped = 4'd9;
    else                    db_clamped = cfg_db;
  end

  assign data_mask = 9'h1FF >> (4'd9 - db_clamped);
  assign tick_end  = b_tick && (tick_q == TW'(OS - 1));
  assign counting  = (state_q == S_START) || (state_q == S_DATA) || (state_q == S_PARITY) ||
                     (state_q == S_STOP)  || (state_q == S_MAB);

  // One-and-a-half stop bits end halfway through the second stop period.
  always_comb begin
    stop_last = 1'b0;
    case (stop_q)
      2'b00:   stop_last = tick_end && (bit_q == 4'd0);
      2'b01:   stop_last = b_tick && (bit_q == 4'd1) && (tick_q == TW'(OS / 2 - 1));
      default: stop_last = tick_end && (bit_q == 4'd1);
    endcase
  end

  always_comb begin
    state_d   = state_q;
    tick_d    = tick_q;
    bit_d     = bit_q;
    shreg_d   = shreg_q;
    db_d      = db_q;
    par_en_d  = par_en_q;
    par_bit_d = par_bit_q;
    stop_d    = stop_q;
    tx_d      = tx_q;
    done_d    = 1'b0;

    if (counting && b_tick) begin
      tick_d = tick_end ? '0 : tick_q + TW'(1);
    end

    case (state_q)
      S_IDLE: begin
        tick_d = '0;
        bit_d  = 4'd0;
        tx_d   = IDLE_LVL;
        if (brk) begin
          state_d = S_BREAK;
          tx_d    = 1'b0;
        end else if (tx_valid) begin
          state_d   = S_START;
          tx_d      = 1'b0;
          shreg_d   = tx_data;
          db_d      = db_clamped;
          par_en_d  = (cfg_par == 2'b01) || (cfg_par == 2'b10);
          par_bit_d = (^(tx_data & data_mask)) ^ (cfg_par == 2'b10);
          stop_d    = cfg_stop;
        end
      end
      S_START: begin
        if (tick_end) begin
          state_d = S_DATA;
          tx_d    = shreg_q[0];
          bit_d   = 4'd0;
        end
      end
      S_DATA: begin
        if (tick_end) begin
          if (bit_q == db_q - 4'd1) begin
            bit_d = 4'd0;
            if (par_en_q) begin
              state_d = S_PARITY;
              tx_d    = par_bit_q;
            end else begin
              state_d = S_STOP;
              tx_d    = IDLE_LVL;
            end
          end else begin
            shreg_d = shreg_q >> 1;
            tx_d    = shreg_q[1];
            bit_d   = bit_q + 4'd1;
          end
        end
      end
      S_PARITY: begin
        if (tick_end) begin
          state_d = S_STOP;
          tx_d    = IDLE_LVL;
          bit_d   = 4'd0;
        end
      end
      S_STOP: begin
        tx_d = IDLE_LVL;
        if (stop_last) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
          tick_d  = '0;
          bit_d   = 4'd0;
        end else if (tick_end) begin
          bit_d = bit_q + 4'd1;
        end
      end
      S_BREAK: begin
        tx_d   = 1'b0;
        tick_d = '0;
        if (!brk) begin
          state_d = S_MAB;
          tx_d    = IDLE_LVL;
        end
      end
      S_MAB: begin
        tx_d = IDLE_LVL;
        if (tick_end) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        tx_d    = IDLE_LVL;
        tick_d  = '0;
        bit_d   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_IDLE;
      tick_q    <= '0;
      bit_q     <= 4'd0;
      shreg_q   <= 9'd0;
      db_q      <= 4'd0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
      stop_q    <= 2'b00;
      tx_q      <= IDLE_LVL;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      tick_q    <= tick_d;
      bit_q     <= bit_d;
      shreg_q   <= shreg_d;
      db_q      <= db_d;
      par_en_q  <= par_en_d;
      par_bit_q <= par_bit_d;
      stop_q    <= stop_d;
      tx_q      <= tx_d;
      done_q    <= done_d;
    end
  end

  assign tx_ready     = (state_q == S_IDLE) && !brk;
  assign busy         = (state_q != S_IDLE);
  assign tx           = tx_q;
  assign tx_done_tick = done_q;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// tb/tb_uart_tx_cfg.sv - randomized self-checking bench for uart_tx_cfg
// Expected line levels come from a half-bit frame list built from the frame rules.
module tb_uart_tx_cfg;

  localparam int OS   = 16;
  localparam int HALF = OS / 2;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       b_tick = 1'b0;
  logic       tx_valid = 1'b0;
  logic [8:0] tx_data = 9'd0;
  logic       tx_ready;
  logic [3:0] cfg_db = 4'd8;
  logic [1:0] cfg_par = 2'b00;
  logic [1:0] cfg_stop = 2'b00;
  logic       brk = 1'b0;
  logic       tx;
  logic       tx_done_tick;
  logic       busy;

  int  checks = 0;
  int  fails = 0;
  int  cyc = 0;
  bit  tick_en = 1'b1;
  bit  edge_tick = 1'b0;
  bit  exp_half [0:31];
  int  exp_nhalf = 0;

  uart_tx_cfg #(.OS(OS), .IDLE_LVL(1'b1)) dut (
    .clock(clock), .reset(reset), .b_tick(b_tick), .tx_valid(tx_valid),
    .tx_data(tx_data), .tx_ready(tx_ready), .cfg_db(cfg_db), .cfg_par(cfg_par),
    .cfg_stop(cfg_stop), .brk(brk), .tx(tx), .tx_done_tick(tx_done_tick), .busy(busy)
  );

  always #5 clock = ~clock;

  // Advance one clock; b_tick for the coming edge is set every fourth cycle.
  task automatic clk();
    edge_tick = b_tick;
    @(posedge clock);
    #1;
    cyc++;
    b_tick = tick_en && (cyc % 4 == 0);
  endtask

  task automatic align();
    for (int i = 0; i < 8 && b_tick !== 1'b1; i++) clk();
  endtask

  task automatic build_model(input logic [8:0] d, input logic [3:0] db,
                             input logic [1:0] par, input logic [1:0] stp);
    int nb, ones, nstop;
    bit p;
    nb = (db < 5) ? 5 : ((db > 9) ? 9 : int'(db));
    exp_nhalf = 0;
    ones = 0;
    exp_half[exp_nhalf++] = 1'b0;
    exp_half[exp_nhalf++] = 1'b0;
    for (int i = 0; i < nb; i++) begin
      exp_half[exp_nhalf++] = d[i];
      exp_half[exp_nhalf++] = d[i];
      ones += int'(d[i]);
    end
    if (par == 2'b01 || par == 2'b10) begin
      p = (ones % 2 == 1) ^ (par == 2'b10);
      exp_half[exp_nhalf++] = p;
      exp_half[exp_nhalf++] = p;
    end
    nstop = (stp == 2'b00) ? 2 : ((stp == 2'b01) ? 3 : 4);
    for (int i = 0; i < nstop; i++) exp_half[exp_nhalf++] = 1'b1;
  endtask

  task automatic send_frame(input logic [8:0] d, input logic [3:0] db, input logic [1:0] par,
                            input logic [1:0] stp, input bit keep_valid, input bit scramble,
                            output int clocks);
    int ticks, n, err, total, bad_n;
    bit got_done, bad_exp;
    logic bad_tx;
    build_model(d, db, par, stp);
    total = exp_nhalf * HALF;
    tx_data = d; cfg_db = db; cfg_par = par; cfg_stop = stp; tx_valid = 1'b1;
    clk();
    checks++;
    if (tx !== 1'b0 || busy !== 1'b1 || tx_ready !== 1'b0) begin
      fails++;
      $display("FAIL accept_latency: tx=%b busy=%b ready=%b, required tx=0 busy=1 ready=0", tx, busy, tx_ready);
    end
    if (!keep_valid) tx_valid = 1'b0;
    ticks = 0; n = 0; err = 0; got_done = 1'b0; bad_n = 0; bad_tx = 1'b0; bad_exp = 1'b0;
    while (n < 3000 && !got_done) begin
      if (scramble) begin
        tx_data = 9'($urandom); cfg_db = 4'($urandom); cfg_par = 2'($urandom); cfg_stop = 2'($urandom);
      end
      clk();
      n++;
      if (edge_tick) ticks++;
      if (ticks < total) begin
        if (tx !== exp_half[ticks / HALF] || busy !== 1'b1 || tx_done_tick !== 1'b0 || tx_ready !== 1'b0) begin
          if (err == 0) begin bad_n = n; bad_tx = tx; bad_exp = exp_half[ticks / HALF]; end
          err++;
        end
      end else begin
        got_done = 1'b1;
      end
    end
    checks++;
    if (err != 0) begin
      fails++;
      $display("FAIL frame_line: %0d bad clocks, first at clock %0d tx=%b required %b (data=%h db=%0d par=%0d stop=%0d)",
               err, bad_n, bad_tx, bad_exp, d, db, par, stp);
    end
    checks++;
    if (!got_done || tx_done_tick !== 1'b1 || busy !== 1'b0 || tx !== 1'b1) begin
      fails++;
      $display("FAIL frame_done: done=%b busy=%b tx=%b after %0d clocks, required done=1 busy=0 tx=1 after %0d ticks",
               tx_done_tick, busy, tx, n, total);
    end
    clocks = n;
  endtask

  task automatic check_pulse_width();
    clk();
    checks++;
    if (tx_done_tick !== 1'b0 || busy !== 1'b0 || tx !== 1'b1) begin
      fails++;
      $display("FAIL done_pulse_width: done=%b busy=%b tx=%b, required done=0 busy=0 tx=1", tx_done_tick, busy, tx);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) clk();
    reset = 1'b0;
    clk();
    checks++;
    if (tx !== 1'b1 || busy !== 1'b0 || tx_done_tick !== 1'b0 || tx_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_state: tx=%b busy=%b done=%b ready=%b, required 1 0 0 1", tx, busy, tx_done_tick, tx_ready);
    end
  endtask

  task automatic test_fixed_frames();
    int c;
    align();
    send_frame(9'h0A5, 4'd8, 2'b00, 2'b00, 1'b0, 1'b0, c);
    checks++;
    if (c != 640) begin fails++; $display("FAIL len_8n1: %0d clocks, required 640", c); end
    check_pulse_width();
    align();
    send_frame(9'h0A5, 4'd8, 2'b01, 2'b10, 1'b0, 1'b1, c);
    checks++;
    if (c != 768) begin fails++; $display("FAIL len_8e2: %0d clocks, required 768", c); end
    check_pulse_width();
    align();
    send_frame(9'h041, 4'd7, 2'b10, 2'b01, 1'b0, 1'b0, c);
    checks++;
    if (c != 672) begin fails++; $display("FAIL len_7o15: %0d clocks, required 672", c); end
    check_pulse_width();
  endtask

  task automatic test_back_to_back();
    int c;
    align();
    send_frame(9'h1FF, 4'd9, 2'b00, 2'b00, 1'b1, 1'b0, c);
    send_frame(9'h000, 4'd9, 2'b00, 2'b00, 1'b0, 1'b0, c);
    check_pulse_width();
  endtask

  task automatic test_clamp();
    int c;
    send_frame(9'($urandom), 4'd3, 2'b01, 2'b00, 1'b0, 1'b1, c);
    check_pulse_width();
    send_frame(9'($urandom), 4'd15, 2'b10, 2'b10, 1'b0, 1'b1, c);
    check_pulse_width();
  endtask

  task automatic test_break();
    int err, ticks, c;
    brk = 1'b1; tx_valid = 1'b1;
    tx_data = 9'h05A; cfg_db = 4'd8; cfg_par = 2'b00; cfg_stop = 2'b00;
    err = 0;
    for (int i = 0; i < 200; i++) begin
      clk();
      if (tx !== 1'b0 || busy !== 1'b1 || tx_ready !== 1'b0 || tx_done_tick !== 1'b0) err++;
    end
    checks++;
    if (err != 0) begin fails++; $display("FAIL break_low: %0d bad clocks of 200, required 0", err); end
    brk = 1'b0;
    clk();
    checks++;
    if (tx !== 1'b1 || busy !== 1'b1) begin
      fails++; $display("FAIL mab_level: tx=%b busy=%b, required tx=1 busy=1", tx, busy);
    end
    ticks = 0; err = 0;
    for (int i = 0; i < 200 && busy === 1'b1; i++) begin
      clk();
      if (edge_tick) ticks++;
      if (tx !== 1'b1 || tx_done_tick !== 1'b0) err++;
    end
    checks++;
    if (ticks != OS || err != 0 || busy !== 1'b0 || tx_ready !== 1'b1) begin
      fails++;
      $display("FAIL mab_length: %0d ticks with %0d bad clocks busy=%b ready=%b, required %0d ticks 0 bad busy=0 ready=1",
               ticks, err, busy, tx_ready, OS);
    end
    send_frame(9'h05A, 4'd8, 2'b00, 2'b00, 1'b0, 1'b0, c);
    check_pulse_width();
  endtask

  task automatic test_hold_and_reset();
    int ticks, err;
    logic held;
    align();
    tx_data = 9'h0F3; cfg_db = 4'd8; cfg_par = 2'b00; cfg_stop = 2'b00; tx_valid = 1'b1;
    clk();
    tx_valid = 1'b0;
    ticks = 0;
    for (int i = 0; i < 400 && ticks < 40; i++) begin
      clk();
      if (edge_tick) ticks++;
    end
    tick_en = 1'b0; b_tick = 1'b0;
    clk();
    held = tx;
    err = 0;
    for (int i = 0; i < 100; i++) begin
      clk();
      if (tx !== held || busy !== 1'b1 || tx_done_tick !== 1'b0) err++;
    end
    checks++;
    if (err != 0 || held !== 1'b1) begin
      fails++; $display("FAIL tick_hold: %0d bad clocks, held level %b, required 0 bad and level 1", err, held);
    end
    tick_en = 1'b1;
    reset = 1'b1;
    clk();
    reset = 1'b0;
    checks++;
    if (tx !== 1'b1 || busy !== 1'b0 || tx_done_tick !== 1'b0) begin
      fails++; $display("FAIL reset_abort: tx=%b busy=%b done=%b, required 1 0 0", tx, busy, tx_done_tick);
    end
    err = 0;
    for (int i = 0; i < 1000; i++) begin
      clk();
      if (tx !== 1'b1 || busy !== 1'b0 || tx_done_tick !== 1'b0) err++;
    end
    checks++;
    if (err != 0) begin fails++; $display("FAIL reset_quiet: %0d bad clocks, required 0", err); end
  endtask

  task automatic test_random();
    int c;
    bit keep;
    for (int k = 0; k < 12; k++) begin
      keep = (k != 11) && ($urandom_range(0, 1) == 1);
      send_frame(9'($urandom), 4'($urandom), 2'($urandom), 2'($urandom), keep, 1'b1, c);
      if (!keep) begin
        check_pulse_width();
        repeat ($urandom_range(0, 10)) clk();
      end
    end
  endtask

  initial begin
    test_reset();
    test_fixed_frames();
    test_back_to_back();
    test_clamp();
    test_break();
    test_hold_and_reset();
    test_random();
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
